// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: byte-serial sequencer for an external 8-bit adder.
// A wide add of two NBYTES-byte operands is split into NBYTES byte steps.
// The steps run LSB first, and each step's carry-out is chained into the next step.
//
// Handshake: start is a request that is accepted only at a rising edge while
// the block is idle. Acceptance is visible as busy=1 in the following cycle.
// A request seen in RUN or DONE is dropped. The requester must still be
// asserting start at a later idle edge for it to be taken.
//
// Optional feature: define OVERFLOW_FLAG_EN to add the ovf_out port. It is a
// two's-complement overflow flag that is registered together with cout_out.
//
// dbg_state exposes the FSM state for checkers: 0=IDLE, 1=RUN, 2=DONE.

module adder_seq_ctrl #(
    parameter  int NBYTES = 4,
    localparam int W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum_out,
    output logic         cout_out,
    output logic [7:0]   add_a,
    output logic [7:0]   add_b,
    output logic         add_cin,
    input  logic [7:0]   add_sum,
    input  logic         add_cout,
`ifdef OVERFLOW_FLAG_EN
    output logic         ovf_out,
`endif
    output logic [1:0]   dbg_state
);

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef OVERFLOW_FLAG_EN
    logic             ovf_q, ovf_d;
`endif

    // Next-state and datapath update: latch on accept, one byte per RUN cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef OVERFLOW_FLAG_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = cin;
                    idx_d   = '0;
                    // Old result is cleared at acceptance.
                    sum_d   = '0;
                    cout_d  = 1'b0;
`ifdef OVERFLOW_FLAG_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[8*idx_q +: 8] = add_sum;
                carry_d             = add_cout;
                idx_d               = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
`ifdef OVERFLOW_FLAG_EN
                    // The top byte's sum bit 7 is bit W-1 of the full result.
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[7] != a_q[W-1]);
`endif
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // busy/done are registered from the next state so they align with the state register.
    always_comb begin
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // All state, including the registered status outputs, is updated here with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef OVERFLOW_FLAG_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Adder drive: the current byte pair in RUN, and quiet zeros otherwise.
    always_comb begin
        add_a   = 8'd0;
        add_b   = 8'd0;
        add_cin = 1'b0;
        if (state_q == S_RUN) begin
            add_a   = a_q[8*idx_q +: 8];
            add_b   = b_q[8*idx_q +: 8];
            add_cin = carry_q;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum_out   = sum_q;
    assign cout_out  = cout_q;
    assign dbg_state = state_q;
`ifdef OVERFLOW_FLAG_EN
    assign ovf_out   = ovf_q;
`endif

    // busy and done are mutually exclusive.
    a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(busy_q && done_q));

    // done is a single-cycle pulse.
    a_done_pulse: assert property (@(posedge clk) disable iff (rst) done_q |=> !done_q);

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Testbench for adder_seq_ctrl (NBYTES=4).
// The 8-bit adder is modelled here as a combinational add.
// Results are predicted from whole-word arithmetic on the operands.
module tb_adder_seq_ctrl;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout_out;
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic         add_cin;
    logic [7:0]   add_sum;
    logic         add_cout;
    logic [1:0]   dbg_state;
`ifdef OVERFLOW_FLAG_EN
    logic         ovf_out;
`endif

    always #5 clk = ~clk;

    // External adder_8bit stand-in.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    adder_seq_ctrl #(.NBYTES(NBYTES)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .cout_out (cout_out),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
`ifdef OVERFLOW_FLAG_EN
        .ovf_out  (ovf_out),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    // Each entry is {ovf, cout, sum}.
    logic [W+1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model using plain wide arithmetic.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic c);
        logic [W:0] s;
        logic       v;
        s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return {v, s};
    endfunction

    // ---------------- driver tasks ----------------
    // This task is entered at the negedge right after the accepting edge.
    // It churns the operands, waits for done and then checks the result.
    task automatic finish_op(input string tag, output logic [W+1:0] e);
        int cyc;
        cyc = 1;
        e   = '0;
        check_eq({tag, "_sum_cleared"}, sum_out, 0);
        check_eq({tag, "_cout_cleared"}, cout_out, 0);
        while (done !== 1'b1 && cyc < 40) begin
            check_eq({tag, "_busy_run"}, busy, 1);
            @(negedge clk);
            a_in = $urandom;
            b_in = $urandom;
            cin  = 1'($urandom_range(0, 1));
            cyc++;
        end
        check_eq({tag, "_done_seen"}, done, 1);
        check_eq({tag, "_latency"}, cyc, NBYTES + 1);
        check_eq({tag, "_busy_in_done"}, busy, 0);
        check_eq({tag, "_exp_avail"}, (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq({tag, "_sum"}, sum_out, e[W-1:0]);
            check_eq({tag, "_cout"}, cout_out, e[W]);
`ifdef OVERFLOW_FLAG_EN
            check_eq({tag, "_ovf"}, ovf_out, e[W+1]);
`endif
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c);
        logic [W+1:0] e;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        cin   = c;
        start = 1'b1;
        exp_q.push_back(ref_add(a, b, c));
        @(negedge clk);
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        cin   = 1'($urandom_range(0, 1));
        finish_op(tag, e);
        @(negedge clk);
        check_eq({tag, "_done_pulse_end"}, done, 0);
        check_eq({tag, "_idle_busy"}, busy, 0);
        check_eq({tag, "_sum_hold"}, sum_out, e[W-1:0]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W+1:0] e;
        logic [W-1:0] ra, rb;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        cin   = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_sum", sum_out, 0);
        check_eq("reset_cout", cout_out, 0);
        check_eq("reset_state", dbg_state, 0);
        check_eq("reset_add_a", add_a, 0);
`ifdef OVERFLOW_FLAG_EN
        check_eq("reset_ovf", ovf_out, 0);
`endif
        rst = 1'b0;

        // Directed cases
        run_op("small",     32'h0000_0002, 32'h0000_0003, 1'b0);
        run_op("byte_cy",   32'h0000_00FF, 32'h0000_0001, 1'b0);
        run_op("all1_c0",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("all1_c1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_op("pos_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        run_op("neg_ovf",   32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("cin_ripple", 32'h00FF_FFFF, 32'h0000_0000, 1'b1);

        // Reset after two RUN edges abandons the operation.
        @(negedge clk);
        a_in  = 32'h1234_5678;
        b_in  = 32'h1111_1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rstmid_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rstmid_busy", busy, 0);
        check_eq("rstmid_done", done, 0);
        check_eq("rstmid_sum", sum_out, 0);
        check_eq("rstmid_cout", cout_out, 0);
        check_eq("rstmid_state", dbg_state, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("rstmid_no_done", done, 0);
        end
        run_op("after_rst", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);

        // start held through RUN while the operands churn, then a second op at the earliest edge.
        @(negedge clk);
        a_in  = 32'h89AB_CDEF;
        b_in  = 32'h7654_3210;
        cin   = 1'b0;
        start = 1'b1;
        exp_q.push_back(ref_add(32'h89AB_CDEF, 32'h7654_3210, 1'b0));
        @(negedge clk);
        finish_op("held1", e);
        ra    = $urandom;
        rb    = $urandom;
        a_in  = ra;
        b_in  = rb;
        cin   = 1'b1;
        exp_q.push_back(ref_add(ra, rb, 1'b1));
        @(negedge clk);
        check_eq("held_idle_gap_busy", busy, 0);
        check_eq("held_idle_gap_sum", sum_out, e[W-1:0]);
        @(negedge clk);
        check_eq("held_reaccept_busy", busy, 1);
        start = 1'b0;
        finish_op("held2", e);

        // Randomized operations with random idle gaps.
        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: ra = '1;
                1: rb = {1'b0, {(W-1){1'b1}}};
                default: ;
            endcase
            run_op("rand", ra, rb, 1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        check_eq("exp_q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
